biriscv_issue_sched: RTL and testbench

Single-issue scheduler sitting between the fetch/decode front end and the execution pipeline controller. It holds one decoded instruction, checks read-after-write hazards against the E1/E2/WB destination tags the pipeline reports back, and selects forwarded operands. It drives the `issue_*` handshake only when the instruction can legally enter E1. It also generates the global issue stall and flush-side cleanup.

---
 rtl/biriscv_defs.sv | 54 +++++
 rtl/biriscv_issue_fwd.sv | 71 +++++++
 rtl/biriscv_issue_sched.sv | 191 +++++++++++++++++++
 tb/tb_biriscv_issue_sched.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/biriscv_defs.sv
// ============================================================================
//  Module      : biriscv_defs (package)
//  Description : Shared definitions for the issue scheduler: datapath widths,
//                instruction register-field positions, front-end exception
//                codes and the packed hold-register payload.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package biriscv_defs;

    localparam int XLEN       = 32;
    localparam int REG_IDX_W  = 5;
    localparam int EXC_W      = 6;

    // Register-index field positions within a 32-bit RISC-V instruction
    localparam int RD_IDX_HI  = 11;
    localparam int RD_IDX_LO  = 7;
    localparam int RS1_IDX_HI = 19;
    localparam int RS1_IDX_LO = 15;
    localparam int RS2_IDX_HI = 24;
    localparam int RS2_IDX_LO = 20;

    // Front-end fault codes (zero means the fetch was clean)
    typedef enum logic [EXC_W-1:0] {
        EXC_NONE             = 6'h00,
        EXC_MISALIGNED_FETCH = 6'h10,
        EXC_FAULT_FETCH      = 6'h11,
        EXC_ILLEGAL_INSTR    = 6'h12,
        EXC_PAGE_FAULT_FETCH = 6'h1c
    } exc_e;

    // Payload captured alongside the hold-register valid bit
    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  instr;
        logic [EXC_W-1:0] exc;
        logic             lsu;
        logic             csr;
        logic             div;
        logic             mul;
        logic             branch;
        logic             rd_valid;
        logic             ra_valid;
        logic             rb_valid;
    } hold_t;

    function automatic logic is_exception(input logic [EXC_W-1:0] exc);
        return (exc != EXC_NONE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/biriscv_issue_fwd.sv
// ============================================================================
//  Module      : biriscv_issue_fwd
//  Description : Per-operand RAW hazard detection and forwarding mux.
//                Ports: i_idx/i_used (source register and whether it is read),
//                i_rf_data (register-file read), E1/E2/WB destination tags,
//                producer classes and results; o_hazard (operand not yet
//                available), o_operand (selected operand value).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module biriscv_issue_fwd
    import biriscv_defs::*;
#(
    parameter int SUPPORT_LOAD_BYPASS = 1,
    parameter int SUPPORT_MUL_BYPASS  = 1
) (
    input  logic [REG_IDX_W-1:0] i_idx,
    input  logic                 i_used,
    input  logic [XLEN-1:0]      i_rf_data,
    input  logic [REG_IDX_W-1:0] i_rd_e1,
    input  logic                 i_load_e1,
    input  logic                 i_mul_e1,
    input  logic [XLEN-1:0]      i_result_e1,
    input  logic [REG_IDX_W-1:0] i_rd_e2,
    input  logic                 i_load_e2,
    input  logic                 i_mul_e2,
    input  logic [XLEN-1:0]      i_result_e2,
    input  logic [REG_IDX_W-1:0] i_rd_wb,
    input  logic [XLEN-1:0]      i_result_wb,
    output logic                 o_hazard,
    output logic [XLEN-1:0]      o_operand
);

    // Without a bypass path the E2 result of that class is not usable yet
    localparam logic c_LOAD_E2_LOCK = (SUPPORT_LOAD_BYPASS == 0);
    localparam logic c_MUL_E2_LOCK  = (SUPPORT_MUL_BYPASS == 0);

    logic w_idx_nz;
    logic w_hit_e1;
    logic w_hit_e2;
    logic w_hit_wb;

    // x0 never matches a producer, so a zero tag ("no destination") is inert
    assign w_idx_nz = (i_idx != '0);
    assign w_hit_e1 = w_idx_nz && (i_idx == i_rd_e1);
    assign w_hit_e2 = w_idx_nz && (i_idx == i_rd_e2);
    assign w_hit_wb = w_idx_nz && (i_idx == i_rd_wb);

    // E1 only ever has an ALU result ready; any other producer class interlocks
    assign o_hazard = i_used &&
                      ((w_hit_e1 && (i_load_e1 || i_mul_e1)) ||
                       (w_hit_e2 && ((i_load_e2 && c_LOAD_E2_LOCK) ||
                                     (i_mul_e2  && c_MUL_E2_LOCK))));

    // Youngest producer wins
    always_comb begin
        o_operand = i_rf_data;
        if (!w_idx_nz)
            o_operand = '0;
        else if (w_hit_e1)
            o_operand = i_result_e1;
        else if (w_hit_e2)
            o_operand = i_result_e2;
        else if (w_hit_wb)
            o_operand = i_result_wb;
    end

endmodule

`default_nettype wire

// File: rtl/biriscv_issue_sched.sv
// ============================================================================
//  Module      : biriscv_issue_sched
//  Description : Single-entry issue scheduler. Holds one decoded instruction,
//                checks RAW hazards against E1/E2/WB tags, selects forwarded
//                operands and presents the issue handshake.
//                Ports: fetch_* (decoded instruction in, fetch_accept_o out),
//                rf_* (register-file read), issue_* (instruction to E1),
//                stall_i/squash_e1_e2_i/flush_i (pipeline control),
//                *_e1/*_e2/*_wb (producer tags, classes and results).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module biriscv_issue_sched
    import biriscv_defs::*;
#(
    parameter int SUPPORT_LOAD_BYPASS = 1,
    parameter int SUPPORT_MUL_BYPASS  = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n,

    input  logic                 fetch_valid_i,
    output logic                 fetch_accept_o,
    input  logic [XLEN-1:0]      fetch_pc_i,
    input  logic [XLEN-1:0]      fetch_instr_i,
    input  logic [EXC_W-1:0]     fetch_exception_i,
    input  logic                 fetch_lsu_i,
    input  logic                 fetch_csr_i,
    input  logic                 fetch_div_i,
    input  logic                 fetch_mul_i,
    input  logic                 fetch_branch_i,
    input  logic                 fetch_rd_valid_i,
    input  logic                 fetch_ra_valid_i,
    input  logic                 fetch_rb_valid_i,

    input  logic [XLEN-1:0]      rf_ra_i,
    input  logic [XLEN-1:0]      rf_rb_i,
    output logic [REG_IDX_W-1:0] rf_ra_idx_o,
    output logic [REG_IDX_W-1:0] rf_rb_idx_o,

    input  logic                 take_interrupt_i,

    output logic                 issue_valid_o,
    output logic                 issue_accept_o,
    output logic                 issue_stall_o,
    output logic                 issue_lsu_o,
    output logic                 issue_csr_o,
    output logic                 issue_div_o,
    output logic                 issue_mul_o,
    output logic                 issue_branch_o,
    output logic                 issue_rd_valid_o,
    output logic                 take_interrupt_o,
    output logic [REG_IDX_W-1:0] issue_rd_o,
    output logic [EXC_W-1:0]     issue_exception_o,
    output logic [XLEN-1:0]      issue_pc_o,
    output logic [XLEN-1:0]      issue_opcode_o,
    output logic [XLEN-1:0]      issue_operand_ra_o,
    output logic [XLEN-1:0]      issue_operand_rb_o,

    input  logic                 stall_i,
    input  logic                 squash_e1_e2_i,
    input  logic                 flush_i,

    input  logic                 load_e1_i,
    input  logic                 mul_e1_i,
    input  logic                 load_e2_i,
    input  logic                 mul_e2_i,
    input  logic [REG_IDX_W-1:0] rd_e1_i,
    input  logic [REG_IDX_W-1:0] rd_e2_i,
    input  logic [REG_IDX_W-1:0] rd_wb_i,
    input  logic [XLEN-1:0]      alu_result_e1_i,
    input  logic [XLEN-1:0]      result_e2_i,
    input  logic [XLEN-1:0]      result_wb_i
);

    logic  r_valid;
    hold_t r_hold;

    hold_t w_fetch;
    logic  w_capture;
    logic  w_fire;
    logic  w_exempt;
    logic  w_hazard;
    logic  w_hazard_ra;
    logic  w_hazard_rb;

    always_comb begin
        w_fetch          = '0;
        w_fetch.pc       = fetch_pc_i;
        w_fetch.instr    = fetch_instr_i;
        w_fetch.exc      = fetch_exception_i;
        w_fetch.lsu      = fetch_lsu_i;
        w_fetch.csr      = fetch_csr_i;
        w_fetch.div      = fetch_div_i;
        w_fetch.mul      = fetch_mul_i;
        w_fetch.branch   = fetch_branch_i;
        w_fetch.rd_valid = fetch_rd_valid_i;
        w_fetch.ra_valid = fetch_ra_valid_i;
        w_fetch.rb_valid = fetch_rb_valid_i;
    end

    // Faulting instructions and interrupt takers never read operands, so they
    // must not wait on producers and must not write a destination.
    assign w_exempt  = is_exception(r_hold.exc) | take_interrupt_i;
    assign w_hazard  = (w_hazard_ra | w_hazard_rb) & ~w_exempt;

    assign w_fire    = r_valid & ~w_hazard & ~stall_i & ~squash_e1_e2_i & ~flush_i;
    assign fetch_accept_o = ~flush_i & (~r_valid | w_fire);
    assign w_capture = fetch_valid_i & fetch_accept_o;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_hold  <= '0;
        end else begin
            if (flush_i)
                r_valid <= 1'b0;
            else if (w_capture)
                r_valid <= 1'b1;
            else if (w_fire)
                r_valid <= 1'b0;

            if (w_capture)
                r_hold <= w_fetch;
        end
    end

    assign rf_ra_idx_o = r_hold.instr[RS1_IDX_HI:RS1_IDX_LO];
    assign rf_rb_idx_o = r_hold.instr[RS2_IDX_HI:RS2_IDX_LO];

    biriscv_issue_fwd #(
        .SUPPORT_LOAD_BYPASS (SUPPORT_LOAD_BYPASS),
        .SUPPORT_MUL_BYPASS  (SUPPORT_MUL_BYPASS)
    ) u_fwd_ra (
        .i_idx       (rf_ra_idx_o),
        .i_used      (r_hold.ra_valid),
        .i_rf_data   (rf_ra_i),
        .i_rd_e1     (rd_e1_i),
        .i_load_e1   (load_e1_i),
        .i_mul_e1    (mul_e1_i),
        .i_result_e1 (alu_result_e1_i),
        .i_rd_e2     (rd_e2_i),
        .i_load_e2   (load_e2_i),
        .i_mul_e2    (mul_e2_i),
        .i_result_e2 (result_e2_i),
        .i_rd_wb     (rd_wb_i),
        .i_result_wb (result_wb_i),
        .o_hazard    (w_hazard_ra),
        .o_operand   (issue_operand_ra_o)
    );

    biriscv_issue_fwd #(
        .SUPPORT_LOAD_BYPASS (SUPPORT_LOAD_BYPASS),
        .SUPPORT_MUL_BYPASS  (SUPPORT_MUL_BYPASS)
    ) u_fwd_rb (
        .i_idx       (rf_rb_idx_o),
        .i_used      (r_hold.rb_valid),
        .i_rf_data   (rf_rb_i),
        .i_rd_e1     (rd_e1_i),
        .i_load_e1   (load_e1_i),
        .i_mul_e1    (mul_e1_i),
        .i_result_e1 (alu_result_e1_i),
        .i_rd_e2     (rd_e2_i),
        .i_load_e2   (load_e2_i),
        .i_mul_e2    (mul_e2_i),
        .i_result_e2 (result_e2_i),
        .i_rd_wb     (rd_wb_i),
        .i_result_wb (result_wb_i),
        .o_hazard    (w_hazard_rb),
        .o_operand   (issue_operand_rb_o)
    );

    assign issue_valid_o     = r_valid;
    assign issue_accept_o    = w_fire;
    assign issue_stall_o     = stall_i;
    assign issue_pc_o        = r_hold.pc;
    assign issue_opcode_o    = r_hold.instr;
    assign issue_exception_o = r_hold.exc;
    assign issue_rd_o        = r_hold.instr[RD_IDX_HI:RD_IDX_LO];
    assign issue_lsu_o       = r_hold.lsu;
    assign issue_csr_o       = r_hold.csr;
    assign issue_div_o       = r_hold.div;
    assign issue_mul_o       = r_hold.mul;
    assign issue_branch_o    = r_hold.branch;
    assign issue_rd_valid_o  = r_hold.rd_valid & ~w_exempt;
    assign take_interrupt_o  = take_interrupt_i & r_valid;

endmodule

`default_nettype wire

// File: tb/tb_biriscv_issue_sched.sv
`default_nettype none

module tb_biriscv_issue_sched;

    localparam int LB = 1;   // load bypass present
    localparam int MB = 0;   // multiply bypass absent

    logic clk_i = 1'b0;
    logic rst_n;
    always #5 clk_i = ~clk_i;

    logic        fetch_valid_i, fetch_accept_o;
    logic [31:0] fetch_pc_i, fetch_instr_i;
    logic [5:0]  fetch_exception_i;
    logic        fetch_lsu_i, fetch_csr_i, fetch_div_i, fetch_mul_i, fetch_branch_i;
    logic        fetch_rd_valid_i, fetch_ra_valid_i, fetch_rb_valid_i;
    logic [31:0] rf_ra_i, rf_rb_i;
    logic [4:0]  rf_ra_idx_o, rf_rb_idx_o;
    logic        take_interrupt_i;
    logic        issue_valid_o, issue_accept_o, issue_stall_o;
    logic        issue_lsu_o, issue_csr_o, issue_div_o, issue_mul_o, issue_branch_o;
    logic        issue_rd_valid_o, take_interrupt_o;
    logic [4:0]  issue_rd_o;
    logic [5:0]  issue_exception_o;
    logic [31:0] issue_pc_o, issue_opcode_o, issue_operand_ra_o, issue_operand_rb_o;
    logic        stall_i, squash_e1_e2_i, flush_i;
    logic        load_e1_i, mul_e1_i, load_e2_i, mul_e2_i;
    logic [4:0]  rd_e1_i, rd_e2_i, rd_wb_i;
    logic [31:0] alu_result_e1_i, result_e2_i, result_wb_i;

    logic [31:0] rf [32];
    assign rf_ra_i = rf[rf_ra_idx_o];
    assign rf_rb_i = rf[rf_rb_idx_o];

    biriscv_issue_sched #(.SUPPORT_LOAD_BYPASS(LB), .SUPPORT_MUL_BYPASS(MB)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .fetch_valid_i(fetch_valid_i), .fetch_accept_o(fetch_accept_o),
        .fetch_pc_i(fetch_pc_i), .fetch_instr_i(fetch_instr_i),
        .fetch_exception_i(fetch_exception_i),
        .fetch_lsu_i(fetch_lsu_i), .fetch_csr_i(fetch_csr_i), .fetch_div_i(fetch_div_i),
        .fetch_mul_i(fetch_mul_i), .fetch_branch_i(fetch_branch_i),
        .fetch_rd_valid_i(fetch_rd_valid_i), .fetch_ra_valid_i(fetch_ra_valid_i),
        .fetch_rb_valid_i(fetch_rb_valid_i),
        .rf_ra_i(rf_ra_i), .rf_rb_i(rf_rb_i),
        .rf_ra_idx_o(rf_ra_idx_o), .rf_rb_idx_o(rf_rb_idx_o),
        .take_interrupt_i(take_interrupt_i),
        .issue_valid_o(issue_valid_o), .issue_accept_o(issue_accept_o),
        .issue_stall_o(issue_stall_o),
        .issue_lsu_o(issue_lsu_o), .issue_csr_o(issue_csr_o), .issue_div_o(issue_div_o),
        .issue_mul_o(issue_mul_o), .issue_branch_o(issue_branch_o),
        .issue_rd_valid_o(issue_rd_valid_o), .take_interrupt_o(take_interrupt_o),
        .issue_rd_o(issue_rd_o), .issue_exception_o(issue_exception_o),
        .issue_pc_o(issue_pc_o), .issue_opcode_o(issue_opcode_o),
        .issue_operand_ra_o(issue_operand_ra_o), .issue_operand_rb_o(issue_operand_rb_o),
        .stall_i(stall_i), .squash_e1_e2_i(squash_e1_e2_i), .flush_i(flush_i),
        .load_e1_i(load_e1_i), .mul_e1_i(mul_e1_i), .load_e2_i(load_e2_i), .mul_e2_i(mul_e2_i),
        .rd_e1_i(rd_e1_i), .rd_e2_i(rd_e2_i), .rd_wb_i(rd_wb_i),
        .alu_result_e1_i(alu_result_e1_i), .result_e2_i(result_e2_i), .result_wb_i(result_wb_i)
    );

    // ---------------- reference model state and scoreboard queues ----------
    typedef struct {
        bit          v;
        logic [31:0] pc, instr;
        logic [5:0]  exc;
        logic        lsu, csr, div, mul, br, rdv, rav, rbv;
    } slot_t;

    typedef struct packed {
        logic fa, iv, ia, st, ti;
    } hs_t;

    typedef struct packed {
        logic [31:0] pc, op, ra, rb;
        logic [5:0]  exc;
        logic [4:0]  rd;
        logic        rdv, ti, lsu, csr, div, mul, br;
    } iss_t;

    slot_t m;
    hs_t   hs_q[$];
    iss_t  iss_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Value an operand must take: youngest producer, x0 reads as zero
    function automatic logic [31:0] ref_operand(input logic [4:0] idx);
        if (idx == 5'd0)      return 32'd0;
        if (idx == rd_e1_i)   return alu_result_e1_i;
        if (idx == rd_e2_i)   return result_e2_i;
        if (idx == rd_wb_i)   return result_wb_i;
        return rf[idx];
    endfunction

    // Operand not yet available: producer in E1 that is not an ALU op, or
    // producer in E2 whose result has no bypass path
    function automatic bit ref_blocked(input logic [4:0] idx, input logic used);
        if (!used || idx == 5'd0) return 0;
        if (idx == rd_e1_i && (load_e1_i || mul_e1_i)) return 1;
        if (idx == rd_e2_i && ((load_e2_i && LB == 0) || (mul_e2_i && MB == 0))) return 1;
        return 0;
    endfunction

    // Evaluate one cycle against the current inputs, queue expectations and
    // advance the model slot to what it holds after the coming edge.
    task automatic model_eval();
        bit   exempt, blocked, fire, acc;
        hs_t  h;
        iss_t e;
        exempt  = (m.exc != 6'd0) || take_interrupt_i;
        blocked = !exempt && (ref_blocked(m.instr[19:15], m.rav) ||
                              ref_blocked(m.instr[24:20], m.rbv));
        fire = m.v && !blocked && !stall_i && !squash_e1_e2_i && !flush_i;
        acc  = !flush_i && (!m.v || fire);
        h.fa = acc; h.iv = m.v; h.ia = fire; h.st = stall_i;
        h.ti = take_interrupt_i && m.v;
        hs_q.push_back(h);
        if (fire) begin
            e.pc = m.pc; e.op = m.instr; e.exc = m.exc; e.rd = m.instr[11:7];
            e.ra = ref_operand(m.instr[19:15]);
            e.rb = ref_operand(m.instr[24:20]);
            e.rdv = m.rdv && !exempt; e.ti = take_interrupt_i;
            e.lsu = m.lsu; e.csr = m.csr; e.div = m.div; e.mul = m.mul; e.br = m.br;
            iss_q.push_back(e);
        end
        if (flush_i)
            m.v = 0;
        else if (fetch_valid_i && acc) begin
            m.v = 1; m.pc = fetch_pc_i; m.instr = fetch_instr_i; m.exc = fetch_exception_i;
            m.lsu = fetch_lsu_i; m.csr = fetch_csr_i; m.div = fetch_div_i;
            m.mul = fetch_mul_i; m.br = fetch_branch_i; m.rdv = fetch_rd_valid_i;
            m.rav = fetch_ra_valid_i; m.rbv = fetch_rb_valid_i;
        end else if (fire)
            m.v = 0;
    endtask

    // ---------------- monitor: pops expectations when the DUT presents them
    always @(negedge clk_i) begin
        hs_t  h;
        iss_t e;
        #2;
        if (mon_en) begin
            if (hs_q.size() > 0) begin
                h = hs_q.pop_front();
                chk("fetch_accept",     32'(fetch_accept_o),   32'(h.fa));
                chk("issue_valid",      32'(issue_valid_o),    32'(h.iv));
                chk("issue_accept",     32'(issue_accept_o),   32'(h.ia));
                chk("issue_stall",      32'(issue_stall_o),    32'(h.st));
                chk("take_interrupt_o", 32'(take_interrupt_o), 32'(h.ti));
            end
            if (issue_accept_o === 1'b1) begin
                if (iss_q.size() == 0) begin
                    chk("unexpected_issue_pc", issue_pc_o, 32'hFFFF_FFFF);
                end else begin
                    e = iss_q.pop_front();
                    chk("issue_pc",       issue_pc_o,             e.pc);
                    chk("issue_opcode",   issue_opcode_o,         e.op);
                    chk("operand_ra",     issue_operand_ra_o,     e.ra);
                    chk("operand_rb",     issue_operand_rb_o,     e.rb);
                    chk("issue_exc",      32'(issue_exception_o), 32'(e.exc));
                    chk("issue_rd",       32'(issue_rd_o),        32'(e.rd));
                    chk("issue_rd_valid", 32'(issue_rd_valid_o),  32'(e.rdv));
                    chk("issue_class",
                        32'({issue_lsu_o, issue_csr_o, issue_div_o, issue_mul_o, issue_branch_o}),
                        32'({e.lsu, e.csr, e.div, e.mul, e.br}));
                end
            end
        end
    end

    // ---------------- stimulus helpers -------------------------------------
    function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic lsu, input logic rav, input logic rbv);
        fetch_valid_i = v; fetch_pc_i = pc; fetch_instr_i = ins; fetch_exception_i = 6'd0;
        fetch_lsu_i = lsu; fetch_csr_i = 0; fetch_div_i = 0; fetch_mul_i = 0;
        fetch_branch_i = 0; fetch_rd_valid_i = 1; fetch_ra_valid_i = rav;
        fetch_rb_valid_i = rbv;
    endtask

    task automatic pipe(input logic [4:0] e1, input logic le1, input logic me1,
                        input logic [4:0] e2, input logic le2, input logic me2,
                        input logic [4:0] wb);
        rd_e1_i = e1; load_e1_i = le1; mul_e1_i = me1;
        rd_e2_i = e2; load_e2_i = le2; mul_e2_i = me2; rd_wb_i = wb;
    endtask

    task automatic ctl(input logic st, input logic sq, input logic fl, input logic ti);
        stall_i = st; squash_e1_e2_i = sq; flush_i = fl; take_interrupt_i = ti;
    endtask

    task automatic run_cycle();
        model_eval();
        @(negedge clk_i);
    endtask

    // ---------------- main sequence ----------------------------------------
    initial begin
        logic [31:0] pcr, ins;
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
        rf[0] = 32'hBAD0_BAD0;   // must never leak out through x0
        offer(0, 0, 0, 0, 0, 0);
        pipe(0, 0, 0, 0, 0, 0, 0);
        ctl(0, 0, 0, 0);
        alu_result_e1_i = 32'h0; result_e2_i = 32'h0; result_wb_i = 32'h0;
        m = '{default: '0};
        rst_n = 0;
        repeat (2) @(negedge clk_i);
        chk("reset_issue_valid",  32'(issue_valid_o),  32'd0);
        chk("reset_issue_accept", 32'(issue_accept_o), 32'd0);
        chk("reset_issue_pc",     issue_pc_o,          32'd0);
        chk("reset_operand_ra",   issue_operand_ra_o,  32'd0);
        rst_n = 1;
        @(negedge clk_i);
        mon_en = 1;

        // Independent ADDs back to back
        offer(1, 32'h0, mk(1, 2, 3), 0, 1, 1); run_cycle();
        offer(1, 32'h4, mk(4, 5, 6), 0, 1, 1); run_cycle();
        offer(1, 32'h8, mk(7, 8, 9), 0, 1, 1); run_cycle();
        offer(0, 0, 0, 0, 0, 0);               run_cycle();
        run_cycle();

        // lw x5 ; add x6,x5,x1 -> one bubble, ra from E2
        offer(1, 32'h10, mk(5, 2, 0), 1, 1, 0); run_cycle();
        offer(1, 32'h14, mk(6, 5, 1), 0, 1, 1); run_cycle();
        offer(0, 0, 0, 0, 0, 0);
        pipe(5, 1, 0, 0, 0, 0, 0);              run_cycle();
        pipe(0, 0, 0, 5, 1, 0, 0); result_e2_i = 32'hDEAD_BEEF; run_cycle();
        pipe(0, 0, 0, 0, 0, 0, 0);              run_cycle();

        // add x7,x0,x0 with E1 result 0x55 and tag 0
        offer(1, 32'h20, mk(7, 0, 0), 0, 1, 1); run_cycle();
        offer(0, 0, 0, 0, 0, 0); alu_result_e1_i = 32'h55; run_cycle();

        // rs1 matches E1 (ALU) and WB -> E1 wins
        offer(1, 32'h24, mk(8, 3, 0), 0, 1, 1); run_cycle();
        offer(0, 0, 0, 0, 0, 0);
        pipe(3, 0, 0, 0, 0, 0, 3); alu_result_e1_i = 32'h11; result_wb_i = 32'h22;
        run_cycle();
        pipe(0, 0, 0, 0, 0, 0, 0);

        // stall for 3 cycles with an instruction pending
        offer(1, 32'h28, mk(9, 1, 2), 0, 1, 1); run_cycle();
        offer(1, 32'h2C, mk(10, 3, 4), 0, 1, 1);
        ctl(1, 0, 0, 0); repeat (3) run_cycle();
        ctl(0, 0, 0, 0); run_cycle();
        offer(0, 0, 0, 0, 0, 0); run_cycle();

        // flush while a hazard is pending
        offer(1, 32'h30, mk(11, 4, 0), 0, 1, 0); run_cycle();
        offer(0, 0, 0, 0, 0, 0); pipe(4, 1, 0, 0, 0, 0, 0); run_cycle();
        offer(1, 32'h34, mk(12, 1, 1), 0, 1, 1); ctl(0, 0, 1, 0); run_cycle();
        ctl(0, 0, 0, 0); pipe(0, 0, 0, 0, 0, 0, 0);
        offer(1, 32'h38, mk(13, 1, 1), 0, 1, 1); run_cycle();
        offer(0, 0, 0, 0, 0, 0); run_cycle();

        // Randomised traffic, small register indices to force tag matches
        pcr = 32'h1000;
        for (int n = 0; n < 1500; n++) begin
            ins = $urandom;
            ins[11:7]  = 5'($urandom_range(0, 4));
            ins[19:15] = 5'($urandom_range(0, 4));
            ins[24:20] = 5'($urandom_range(0, 4));
            offer(1'($urandom_range(0, 3) != 0), pcr, ins, 1'($urandom),
                  1'($urandom), 1'($urandom));
            fetch_exception_i = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            fetch_csr_i = 1'($urandom); fetch_div_i = 1'($urandom);
            fetch_mul_i = 1'($urandom); fetch_branch_i = 1'($urandom);
            fetch_rd_valid_i = 1'($urandom);
            pipe(5'($urandom_range(0, 4)), 1'($urandom), 1'($urandom),
                 5'($urandom_range(0, 4)), 1'($urandom), 1'($urandom),
                 5'($urandom_range(0, 4)));
            alu_result_e1_i = $urandom; result_e2_i = $urandom; result_wb_i = $urandom;
            ctl(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0),
                1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) == 0));
            pcr = pcr + 32'd4;
            run_cycle();
        end
        mon_en = 0;
        #3;
        chk("leftover_issue_expectations", 32'(iss_q.size()), 32'd0);

        // Asynchronous reset in the middle of a hazard
        ctl(0, 0, 0, 0); pipe(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        offer(1, 32'h200, mk(14, 2, 0), 0, 1, 0);
        @(negedge clk_i);
        offer(0, 0, 0, 0, 0, 0); pipe(2, 1, 0, 0, 0, 0, 0);
        #2;
        chk("hazard_hold_valid", 32'(issue_valid_o), 32'd1);
        rst_n = 0;
        #1;
        chk("async_reset_valid",  32'(issue_valid_o),  32'd0);
        chk("async_reset_accept", 32'(issue_accept_o), 32'd0);
        chk("async_reset_pc",     issue_pc_o,          32'd0);
        chk("async_reset_opcode", issue_opcode_o,      32'd0);
        @(negedge clk_i);
        rst_n = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
